// File: rtl/can_clic_seq.sv
// can_clic_seq: registered interrupt selector with claim/complete handshake
// and a priority stack for preemptive nesting.
module can_clic_seq #(
   parameter int N_IRQ  = 8,
   parameter int PRIO_W = 3,
   parameter int NEST   = 4,
   parameter int IDX_W  = $clog2(N_IRQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_IRQ-1:0]        irq_i,
   input  logic [N_IRQ-1:0]        enable_i,
   input  logic [N_IRQ-1:0]        edge_i,
   input  logic [N_IRQ*PRIO_W-1:0] prio_i,
   input  logic [PRIO_W-1:0]       threshold_i,
   output logic                    irq_valid_o,
   output logic [IDX_W-1:0]        irq_index_o,
   output logic [PRIO_W-1:0]       irq_prio_o,
   input  logic                    claim_i,
   input  logic                    complete_i,
   input  logic [IDX_W-1:0]        complete_index_i,
   output logic [PRIO_W-1:0]       active_prio_o,
   output logic                    nest_full_o
);
   localparam int SP_W = $clog2(NEST + 1);

   logic [N_IRQ-1:0] irq_q, pend_q, pend_d, insv_q, insv_d, edge_pend, arb_pend, elig;
   logic [NEST-1:0][PRIO_W-1:0] lvl_q, lvl_d;
   logic [SP_W-1:0] sp_q, sp_d, sp_mid;
   logic arm_q, claim, pop;
   logic valid_q, valid_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [PRIO_W-1:0] prio_q, prio_d, act_d, floor_d;

   always_comb begin
      claim = claim_i & valid_q;
      pop = complete_i & (sp_q != '0);
      sp_mid = sp_q - SP_W'(pop);
      sp_d = sp_mid + SP_W'(claim);
      insv_d = insv_q;
      if (pop) insv_d[complete_index_i] = 1'b0;
      if (claim) insv_d[index_q] = 1'b1;
      lvl_d = lvl_q;
      for (int i = 0; i < NEST; i++) if (claim && sp_mid == SP_W'(i)) lvl_d[i] = prio_q;
      act_d = '0;
      for (int i = 0; i < NEST; i++) if (sp_d == SP_W'(i + 1)) act_d = lvl_d[i];
      floor_d = act_d > threshold_i ? act_d : threshold_i;
      valid_d = 1'b0;
      index_d = '0;
      prio_d = '0;
      // Newly latched edges only become visible one cycle later, which gives the 2-cycle edge latency.
      for (int k = 0; k < N_IRQ; k++) begin
         edge_pend[k] = pend_q[k] & ~(claim && index_q == IDX_W'(k));
         pend_d[k] = edge_i[k] ? edge_pend[k] | (arm_q & irq_i[k] & ~irq_q[k]) : irq_i[k] & ~insv_d[k];
         arb_pend[k] = edge_i[k] ? edge_pend[k] : pend_d[k];
         elig[k] = arb_pend[k] & enable_i[k] & ~insv_d[k] & (sp_d < SP_W'(NEST))
                 & (prio_i[k*PRIO_W +: PRIO_W] > floor_d);
         if (elig[k] && (!valid_d || prio_i[k*PRIO_W +: PRIO_W] > prio_d)) begin
            valid_d = 1'b1;
            index_d = IDX_W'(k);
            prio_d = prio_i[k*PRIO_W +: PRIO_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q   <= 1'b0;
         irq_q   <= '0;
         pend_q  <= '0;
         insv_q  <= '0;
         lvl_q   <= '0;
         sp_q    <= '0;
         valid_q <= 1'b0;
         index_q <= '0;
         prio_q  <= '0;
      end else begin
         arm_q   <= 1'b1;
         irq_q   <= irq_i;
         pend_q  <= pend_d;
         insv_q  <= insv_d;
         lvl_q   <= lvl_d;
         sp_q    <= sp_d;
         valid_q <= valid_d;
         index_q <= index_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin
      active_prio_o = '0;
      for (int i = 0; i < NEST; i++) if (sp_q == SP_W'(i + 1)) active_prio_o = lvl_q[i];
   end

   assign nest_full_o = sp_q == SP_W'(NEST);
   assign irq_valid_o = valid_q;
   assign irq_index_o = index_q;
   assign irq_prio_o  = prio_q;
endmodule
